// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter that shares one external combinational
//               ALU between two valid/ready requesters. Each accepted request
//               is registered, executed for one cycle, and its result and
//               zero flag are returned on the owning response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // requester 0
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [2:0]       req0_op_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    output logic [WIDTH-1:0] rsp0_data_o,
    output logic             rsp0_zero_o,
    // requester 1
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [2:0]       req1_op_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [WIDTH-1:0] rsp1_data_o,
    output logic             rsp1_zero_o,
    // shared ALU
    output logic [2:0]       alu_op_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_data_i,
    input  logic             alu_zero_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_grant;
    logic             r_prio;

    logic             w_winner;
    logic             w_accept;
    logic             w_rsp_hs;

    // Winner selection: a lone requester wins, a tie goes to r_prio.
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            w_winner = r_prio;
        end else if (req1_valid_i) begin
            w_winner = 1'b1;
        end
        // Readies are gated by reset so every output reads 0 while it is held.
        w_accept     = (r_state == S_IDLE) && (req0_valid_i || req1_valid_i) && !rst_i;
        req0_ready_o = w_accept && (w_winner == 1'b0);
        req1_ready_o = w_accept && (w_winner == 1'b1);
        w_rsp_hs     = (r_state == S_RESP) &&
                       ((r_grant == 1'b0) ? rsp0_ready_i : rsp1_ready_i);
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, result capture and round-robin priority update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op    <= 3'd0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_zero  <= 1'b0;
            r_grant <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_winner;
                r_op    <= w_winner ? req1_op_i : req0_op_i;
                r_a     <= w_winner ? req1_a_i  : req0_a_i;
                r_b     <= w_winner ? req1_b_i  : req0_b_i;
            end
            if (r_state == S_EXEC) begin
                r_res  <= alu_data_i;
                r_zero <= alu_zero_i;
            end
            if (w_rsp_hs) begin
                r_prio <= ~r_grant;
            end
        end
    end

    // ALU operands come only from registers, so no requester-to-ALU comb path.
    assign alu_op_o     = r_op;
    assign alu_a_o      = r_a;
    assign alu_b_o      = r_b;

    assign rsp0_valid_o = (r_state == S_RESP) && (r_grant == 1'b0);
    assign rsp1_valid_o = (r_state == S_RESP) && (r_grant == 1'b1);
    assign rsp0_data_o  = r_res;
    assign rsp1_data_o  = r_res;
    assign rsp0_zero_o  = r_zero;
    assign rsp1_zero_o  = r_zero;
    assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a small
//               behavioural ALU attached to the shared-ALU port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a, req0_b, rsp0_data;
    logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a, req1_b, rsp1_data;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_data;
    logic             alu_zero, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .rsp0_valid_o (rsp0_valid),
        .rsp0_ready_i (rsp0_ready),
        .rsp0_data_o  (rsp0_data),
        .rsp0_zero_o  (rsp0_zero),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .rsp1_valid_o (rsp1_valid),
        .rsp1_ready_i (rsp1_ready),
        .rsp1_data_o  (rsp1_data),
        .rsp1_zero_o  (rsp1_zero),
        .alu_op_o     (alu_op),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_data_i   (alu_data),
        .alu_zero_i   (alu_zero),
        .busy_o       (busy)
    );

    // Behavioural shared ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others or.
    always_comb begin
        case (alu_op)
            3'd0:    alu_data = alu_a + alu_b;
            3'd1:    alu_data = alu_a - alu_b;
            3'd2:    alu_data = alu_a & alu_b;
            3'd4:    alu_data = alu_a ^ alu_b;
            default: alu_data = alu_a | alu_b;
        endcase
        alu_zero = (alu_data == '0);
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},   {31'd0, busy},       32'd0);
        check({tag, " rdy0"},   {31'd0, req0_ready}, 32'd0);
        check({tag, " rdy1"},   {31'd0, req1_ready}, 32'd0);
        check({tag, " rv0"},    {31'd0, rsp0_valid}, 32'd0);
        check({tag, " rv1"},    {31'd0, rsp1_valid}, 32'd0);
        check({tag, " aluop"},  {29'd0, alu_op},     32'd0);
        check({tag, " alua"},   alu_a,               32'd0);
        check({tag, " alub"},   alu_b,               32'd0);
        check({tag, " rdata"},  rsp0_data,           32'd0);
        check({tag, " rzero"},  {31'd0, rsp0_zero},  32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] exp0 [$];
        logic [WIDTH-1:0] exp1 [$];
        int i0, i1, j0, j1, g, busy_cnt;

        rst        = 1'b1;
        req0_valid = 1'b1;   // valid during reset must not produce a ready
        req0_op    = 3'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0;
        req1_op    = 3'd0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // ---------------- ADD on port 0: 5 + 7 ----------------
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        check("add rdy0 T",  {31'd0, req0_ready}, 32'd1);
        check("add busy T",  {31'd0, busy},       32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("add busy T1", {31'd0, busy},       32'd1);
        check("add alua T1", alu_a,               32'd5);
        check("add alub T1", alu_b,               32'd7);
        check("add rv0 T1",  {31'd0, rsp0_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("add rv0 T2",  {31'd0, rsp0_valid}, 32'd1);
        check("add data",    rsp0_data,           32'd12);
        check("add zero",    {31'd0, rsp0_zero},  32'd0);
        check("add rv1 T2",  {31'd0, rsp1_valid}, 32'd0);
        @(negedge clk);
        #1;
        check("add busy T3", {31'd0, busy},       32'd0);
        check("add rv0 T3",  {31'd0, rsp0_valid}, 32'd0);

        // ---------------- SUB on port 1: 9 - 9 ----------------
        @(negedge clk);
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 32'd9; req1_b = 32'd9;
        #1 check("sub rdy1", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (busy) busy_cnt++;
            if (rsp1_valid) begin
                check("sub data", rsp1_data,          32'd0);
                check("sub zero", {31'd0, rsp1_zero}, 32'd1);
            end
            @(negedge clk);
        end
        check("sub busy cycles", busy_cnt, 32'd2);

        // ---------------- fairness: both valid, 6 requests each ----------------
        i0 = 0; i1 = 0; j0 = 0; j1 = 0; g = 0;
        for (int cyc = 0; cyc < 80 && !(j0 == 6 && j1 == 6); cyc++) begin
            req0_valid = (i0 < 6);
            req0_op    = 3'd0;
            req0_a     = 32'h100 + i0;
            req0_b     = 32'd3 * i0 + 32'd1;
            req1_valid = (i1 < 6);
            req1_op    = 3'd0;
            req1_a     = 32'h200 + i1;
            req1_b     = 32'd3 * i1 + 32'd1;
            #1;
            if (req0_ready) begin
                check("fair grant", 32'd0, g % 2);
                exp0.push_back(req0_a + req0_b);
                g++;
            end
            if (req1_ready) begin
                check("fair grant", 32'd1, g % 2);
                exp1.push_back(req1_a + req1_b);
                g++;
            end
            if (rsp0_valid) begin
                check("fair rsp0", rsp0_data, (exp0.size() > 0) ? exp0.pop_front() : 32'hDEAD_BEEF);
                j0++;
            end
            if (rsp1_valid) begin
                check("fair rsp1", rsp1_data, (exp1.size() > 0) ? exp1.pop_front() : 32'hDEAD_BEEF);
                j1++;
            end
            if (req0_ready) i0++;
            if (req1_ready) i1++;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("fair done0", j0, 32'd6);
        check("fair done1", j1, 32'd6);

        // ---------------- backpressure on port 0, req1 pending ----------------
        @(negedge clk);
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd20; req0_b = 32'd22;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'd1;  req1_b = 32'd2;
        #1;
        check("bp rdy0", {31'd0, req0_ready}, 32'd1);
        check("bp rdy1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1 check("bp rdy1 exec", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp rv0 held",   {31'd0, rsp0_valid}, 32'd1);
            check("bp data held",  rsp0_data,           32'd42);
            check("bp rdy1 held",  {31'd0, req1_ready}, 32'd0);
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        #1;
        check("bp rv0 hs",  {31'd0, rsp0_valid}, 32'd1);
        check("bp rdy1 hs", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        #1 check("bp rdy1 after", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        check("bp rv1",   {31'd0, rsp1_valid}, 32'd1);
        check("bp data1", rsp1_data,           32'd3);
        @(negedge clk);

        // ---------------- reset during EXEC ----------------
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'd3; req0_b = 32'd4;
        #1 check("rst rdy0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1 check("rst busy exec", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1 check_all_zero("rst mid");
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'd10; req0_b = 32'd11;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'd50; req1_b = 32'd60;
        #1;
        check("post rst busy", {31'd0, busy},       32'd0);
        check("post rst rdy0", {31'd0, req0_ready}, 32'd1);
        check("post rst rdy1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #1 check("post rst data", rsp0_data, 32'd21);
        @(negedge clk);

        // ---------------- opcode pass-through ----------------
        req1_valid = 1'b1; req1_op = 3'b101;
        req1_a = 32'hFFFF_0000; req1_b = 32'h0000_FFFF;
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        check("pt op", {29'd0, alu_op}, 32'd5);
        check("pt a",  alu_a,           32'hFFFF_0000);
        check("pt b",  alu_b,           32'h0000_FFFF);
        @(negedge clk);
        #1;
        check("pt rv1",  {31'd0, rsp1_valid}, 32'd1);
        check("pt data", rsp1_data,           32'hFFFF_FFFF);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU instance between two requesters (e.g. the main datapath and an address/branch-compare unit) using valid/ready handshakes and round-robin arbitration. Each accepted request is registered, driven to the shared ALU for one execute cycle, and its result and zero flag are registered and returned on that requester's response channel. The block sits between the requesters and the external ALU. It never decodes the 3-bit ALU opcode; it passes the opcode through.

## Interface
- WIDTH, 32, operand/result width
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- req0_valid_i  in  1  requester 0 has a request
- req0_ready_o  out  1  request 0 accepted this cycle
- req0_op_i  in  3  ALU opcode, passed through unmodified
- req0_a_i, req0_b_i  in  WIDTH  operands
- rsp0_valid_o  out  1  result for requester 0 is available
- rsp0_ready_i  in  1  requester 0 consumes the result
- rsp0_data_o  out  WIDTH  registered ALU result
- rsp0_zero_o  out  1  registered ALU zero flag
- req1_*, rsp1_*: same as the port-0 signals, for requester 1
- alu_op_o  out  3  opcode to the shared ALU
- alu_a_o, alu_b_o  out  WIDTH  operands to the shared ALU
- alu_data_i  in  WIDTH  ALU result (combinational from alu_*_o)
- alu_zero_i  in  1  ALU zero flag
- busy_o  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. The state resets to IDLE.
- Registers:
  - op_q, a_q, b_q hold the captured request.
  - res_q, zero_q hold the captured result.
  - grant_q (0/1) records the owner of the current transaction.
  - prio_q (0/1) records which requester wins a tie.
- IDLE:
  - If exactly one reqN_valid_i is high, that requester wins.
  - If both are high, requester prio_q wins.
  - reqN_ready_o is high only for the winner, only in IDLE, and only while its valid is high. It is combinational from the valid inputs.
  - On acceptance: capture op/a/b into op_q/a_q/b_q, set grant_q to the winner, go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly one cycle): capture alu_data_i into res_q and alu_zero_i into zero_q, then go to RESP.
- RESP:
  - rspN_valid_o is high for N = grant_q. The other response valid stays low.
  - When rspN_ready_i is high: set prio_q to the inverse of grant_q and go to IDLE.
  - Stay in RESP indefinitely while ready is low. res_q and zero_q hold stable during that time.
- alu_op_o, alu_a_o, alu_b_o are always driven from op_q, a_q, b_q. They therefore stay stable between transactions and add no combinational path from requester inputs.
- rspN_data_o and rspN_zero_o are both driven from res_q and zero_q. Their value is meaningful only while rspN_valid_o is high.
- Handshake rules:
  - A requester holds valid and payload stable until ready is seen.
  - reqN_valid_i must not depend combinationally on reqN_ready_o.
- A request that stays pending during another requester's transaction is not lost. It is served in the next IDLE cycle.
- Reset values: state IDLE; op_q=0, a_q=0, b_q=0, res_q=0; zero_q=0; grant_q=0; prio_q=0 (requester 0 wins the first tie). Every output is 0 during reset, including busy_o and all ready and valid outputs.
- Reset asserted mid-transaction aborts it immediately. No response is produced and the requester must reissue.

## Timing
- Request accepted in the cycle T where valid and ready are both high. EXEC is cycle T+1. rspN_valid_o is first high in T+2.
- Minimum transaction length is 3 cycles. The earliest next acceptance is the cycle after the response handshake. Peak throughput is one operation every 3 cycles.
- The response handshake completes in the first cycle with rspN_valid_o=1 and rspN_ready_i=1. With rspN_ready_i held high, the FSM returns to IDLE at T+3.
- busy_o is high from T+1 through the response-handshake cycle.
- Arbitration is evaluated only in IDLE. A valid rising during EXEC or RESP has no effect until IDLE.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…

## Test plan
- Single ADD on port 0, a=5, b=7, rsp0_ready_i held high:
  - req0_ready_o=1 in cycle T; alu_a_o=5 in T+1.
  - rsp0_valid_o=1, rsp0_data_o=12, rsp0_zero_o=0 in T+2.
  - rsp1_valid_o stays 0 throughout.
- SUB on port 1, a=9, b=9 → rsp1_data_o=0, rsp1_zero_o=1. busy_o is high for exactly 2 cycles with ready held high.
- Both valid every cycle, 6 requests each, distinct operands:
  - Grants are 0,1,0,1,… after reset.
  - Each response carries its own requester's result; no starvation.
- Backpressure: rsp0_ready_i held low for 5 cycles during RESP.
  - rsp0_valid_o and rsp0_data_o stay stable.
  - A pending req1 is not accepted until one cycle after the rsp0 handshake.
- Reset asserted during EXEC:
  - All outputs are 0 at once; the state is IDLE after release.
  - With both requesters valid after release, requester 0 is granted first.
- Opcode pass-through: drive op=3'b101 with a=0xFFFF_0000, b=0x0000_FFFF. alu_op_o=3'b101 and both operands appear unmodified on alu_a_o/alu_b_o in EXEC.
